// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction fetch at a time, and predicts the
// next PC from a direct-mapped BTB with 2-bit counters trained by EX.
module fetch_stage #(
    parameter int              XLEN        = 32,
    parameter int              ILEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_1000,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    input  logic            resolve_valid_in,
    input  logic [XLEN-1:0] resolve_pc_in,
    input  logic [XLEN-1:0] resolve_target_in,
    input  logic            resolve_taken_in,
    output logic            imem_req_valid_out,
    output logic [XLEN-1:0] imem_req_addr_out,
    input  logic            imem_req_ready_in,
    input  logic            imem_resp_valid_in,
    input  logic [ILEN-1:0] imem_resp_data_in,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic            pred_taken_out,
    output logic            imem_stall_out
);

    localparam int              IDX   = $clog2(BTB_ENTRIES);
    localparam int              TAG_W = XLEN - IDX - 2;
    localparam logic [ILEN-1:0] NOP   = ILEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [ILEN-1:0] hold_data_reg, hold_data_next;
    logic            hold_pred_reg, hold_pred_next;
    logic [XLEN-1:0] hold_npc_reg, hold_npc_next;

    logic            fetch_valid;
    logic [ILEN-1:0] fetch_data;
    logic            fetch_pred;
    logic            show_fetch;

    // BTB contents gathered from the per-entry storage below
    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  lk_npc;

    logic [IDX-1:0]   rs_idx;
    logic [TAG_W-1:0] rs_tag;

    logic             unused_bits;

    assign unused_bits = ^{pc_reg[1:0], resolve_pc_in[1:0]};

    // Lookup on the current PC
    assign lk_idx   = pc_reg[IDX+1:2];
    assign lk_tag   = pc_reg[XLEN-1:IDX+2];
    assign lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && btb_ctr[lk_idx][1];
    assign pc_plus4 = pc_reg + XLEN'(4);
    assign lk_npc   = lk_taken ? btb_target[lk_idx] : pc_plus4;

    assign rs_idx = resolve_pc_in[IDX+1:2];
    assign rs_tag = resolve_pc_in[XLEN-1:IDX+2];

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [XLEN-1:0]  target_reg;
            logic [1:0]       ctr_reg;
            logic             sel;
            logic             hit;

            assign sel = resolve_valid_in && (rs_idx == IDX'(gi));
            assign hit = valid_reg && (tag_reg == rs_tag);

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                end else if (sel && resolve_taken_in) begin
                    valid_reg <= 1'b1;
                end
            end

            // Tag/target/counter need no reset: they are only read behind valid_reg
            always_ff @(posedge clk) begin
                if (sel && resolve_taken_in) begin
                    tag_reg    <= rs_tag;
                    target_reg <= resolve_target_in;
                    if (hit) begin
                        ctr_reg <= (ctr_reg == 2'b11) ? 2'b11 : ctr_reg + 2'b01;
                    end else begin
                        ctr_reg <= 2'b10;
                    end
                end else if (sel && hit) begin
                    ctr_reg <= (ctr_reg == 2'b00) ? 2'b00 : ctr_reg - 2'b01;
                end
            end

            assign btb_valid[gi]  = valid_reg;
            assign btb_tag[gi]    = tag_reg;
            assign btb_target[gi] = target_reg;
            assign btb_ctr[gi]    = ctr_reg;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        hold_data_next = hold_data_reg;
        hold_pred_next = hold_pred_reg;
        hold_npc_next  = hold_npc_reg;
        fetch_valid    = 1'b0;
        fetch_data     = NOP;
        fetch_pred     = 1'b0;

        case (state_reg)
            S_WAIT: begin
                if (imem_resp_valid_in) begin
                    fetch_valid = 1'b1;
                    fetch_data  = imem_resp_data_in;
                    fetch_pred  = lk_taken;
                end
            end
            S_HOLD: begin
                fetch_valid = 1'b1;
                fetch_data  = hold_data_reg;
                fetch_pred  = hold_pred_reg;
            end
            default: ;
        endcase

        if (redirect_valid_in) begin
            pc_next = redirect_pc_in;
            case (state_reg)
                // A request accepted in the same cycle still owes a response; drop it
                S_REQ:          state_next = imem_req_ready_in ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_next = imem_resp_valid_in ? S_REQ : S_DROP;
                default:        state_next = S_REQ;
            endcase
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (imem_req_ready_in) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_in) begin
                        if (stall_in) begin
                            hold_data_next = imem_resp_data_in;
                            hold_pred_next = lk_taken;
                            hold_npc_next  = lk_npc;
                            state_next     = S_HOLD;
                        end else begin
                            pc_next    = lk_npc;
                            state_next = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    // Advance with the prediction captured when the word arrived
                    if (!stall_in) begin
                        pc_next    = hold_npc_reg;
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid_in) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_REQ;
            pc_reg        <= RESET_PC;
            hold_data_reg <= NOP;
            hold_pred_reg <= 1'b0;
            hold_npc_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            hold_data_reg <= hold_data_next;
            hold_pred_reg <= hold_pred_next;
            hold_npc_reg  <= hold_npc_next;
        end
    end

    assign show_fetch         = fetch_valid && !redirect_valid_in && !reset;
    assign imem_req_valid_out = reset || (state_reg == S_REQ);
    assign imem_req_addr_out  = reset ? RESET_PC : pc_reg;
    assign instr_out          = show_fetch ? fetch_data : NOP;
    assign pred_taken_out     = show_fetch && fetch_pred;
    assign imem_stall_out     = !show_fetch;
    assign pc_out             = pc_reg;
    assign pc_plus4_out       = pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a short random soak, checked every
// cycle against a fetch-stream/BTB model and pinned by hand-computed literals.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        resolve_valid_in;
    logic [31:0] resolve_pc_in;
    logic [31:0] resolve_target_in;
    logic        resolve_taken_in;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        pred_taken_out;
    logic        imem_stall_out;

    fetch_stage #(
        .XLEN(32), .ILEN(32), .RESET_PC(32'h0000_1000), .BTB_ENTRIES(16)
    ) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in),
        .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
        .resolve_valid_in(resolve_valid_in), .resolve_pc_in(resolve_pc_in),
        .resolve_target_in(resolve_target_in), .resolve_taken_in(resolve_taken_in),
        .imem_req_valid_out(imem_req_valid_out), .imem_req_addr_out(imem_req_addr_out),
        .imem_req_ready_in(imem_req_ready_in), .imem_resp_valid_in(imem_resp_valid_in),
        .imem_resp_data_in(imem_resp_data_in), .instr_out(instr_out), .pc_out(pc_out),
        .pc_plus4_out(pc_plus4_out), .pred_taken_out(pred_taken_out),
        .imem_stall_out(imem_stall_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_bv   [16];
    logic [31:0] m_bpc  [16];
    logic [31:0] m_btgt [16];
    int          m_bctr [16];

    logic [31:0] m_pc, m_npc;
    logic        m_out, m_stale, m_hold, m_pred;
    logic        exp_req, exp_valid;

    task automatic predict(input logic [31:0] p, output logic t, output logic [31:0] n);
        int i;
        i = int'(p[5:2]);
        t = m_bv[i] && (m_bpc[i][31:2] == p[31:2]) && (m_bctr[i] >= 2);
        n = t ? m_btgt[i] : p + 32'd4;
    endtask

    task automatic train(input logic [31:0] p, input logic tk, input logic [31:0] tg);
        int   i;
        logic hit;
        i   = int'(p[5:2]);
        hit = m_bv[i] && (m_bpc[i][31:2] == p[31:2]);
        if (tk) begin
            m_btgt[i] = tg;
            if (hit) begin
                m_bctr[i] = (m_bctr[i] < 3) ? m_bctr[i] + 1 : 3;
            end else begin
                m_bv[i]   = 1'b1;
                m_bpc[i]  = p;
                m_bctr[i] = 2;
            end
        end else if (hit) begin
            m_bctr[i] = (m_bctr[i] > 0) ? m_bctr[i] - 1 : 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
            chk("rst_instr", instr_out, NOP);
            chk("rst_pred", {31'd0, pred_taken_out}, 32'd0);
            chk("rst_stall", {31'd0, imem_stall_out}, 32'd1);
            m_pc = RST_PC; m_npc = '0;
            m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_pred = 1'b0;
            for (int k = 0; k < 16; k++) m_bv[k] = 1'b0;
        end else begin
            exp_req = !m_out && !m_hold;
            chk("req_valid", {31'd0, imem_req_valid_out}, {31'd0, exp_req});
            if (exp_req) chk("req_addr", imem_req_addr_out, m_pc);
            exp_valid = !redirect_valid_in &&
                        ((imem_resp_valid_in && m_out && !m_stale) || m_hold);
            if (exp_valid && !m_hold) begin
                predict(m_pc, m_pred, m_npc);
                $display("fetch pc=%h instr=%h pred=%0d", m_pc, mem_word(m_pc), m_pred);
            end
            chk("stall_out", {31'd0, imem_stall_out}, {31'd0, !exp_valid});
            if (exp_valid) begin
                chk("instr", instr_out, mem_word(m_pc));
                chk("pc_out", pc_out, m_pc);
                chk("pc_plus4", pc_plus4_out, m_pc + 32'd4);
                chk("pred", {31'd0, pred_taken_out}, {31'd0, m_pred});
            end else begin
                chk("instr_nop", instr_out, NOP);
                chk("pred_off", {31'd0, pred_taken_out}, 32'd0);
            end
            // state the next cycle must reflect
            if (redirect_valid_in) begin
                if (m_out && !imem_resp_valid_in) m_stale = 1'b1;
                m_pc   = redirect_pc_in;
                m_hold = 1'b0;
            end else if (exp_valid) begin
                if (stall_in) begin
                    m_hold = 1'b1;
                end else begin
                    m_pc   = m_npc;
                    m_hold = 1'b0;
                end
            end
            if (imem_resp_valid_in && m_out) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req && imem_req_ready_in) begin
                m_out   = 1'b1;
                m_stale = redirect_valid_in;
            end
            if (resolve_valid_in) train(resolve_pc_in, resolve_taken_in, resolve_target_in);
        end
    end

    // ---------------- memory responder and stimulus ----------------
    typedef struct {
        logic [31:0] addr;
        int          delay;
    } mreq_t;
    mreq_t q[$];
    int    lat = 1;

    task automatic step();
        logic        hs;
        logic [31:0] ha;
        mreq_t       e;
        @(negedge clk);
        hs = imem_req_valid_out && imem_req_ready_in;
        ha = imem_req_addr_out;
        @(posedge clk);
        #1;
        redirect_valid_in  = 1'b0;
        resolve_valid_in   = 1'b0;
        imem_resp_valid_in = 1'b0;
        imem_resp_data_in  = 32'hDEAD_BEEF;
        if (hs) begin
            e.addr = ha; e.delay = lat;
            q.push_back(e);
        end
        if (q.size() > 0) begin
            if (q[0].delay <= 1) begin
                imem_resp_valid_in = 1'b1;
                imem_resp_data_in  = mem_word(q[0].addr);
                void'(q.pop_front());
            end else begin
                q[0].delay = q[0].delay - 1;
            end
        end
        #1;
    endtask

    task automatic wait_deliver(input string name);
        int n;
        n = 0;
        step();
        while (imem_stall_out && n < 20) begin
            step();
            n++;
        end
        if (imem_stall_out) begin
            checks++;
            failures++;
            $display("FAIL %s: no instruction within 20 cycles, got stall=1 expected 0", name);
        end
    endtask

    task automatic resolve(input logic [31:0] p, input logic tk, input logic [31:0] tg);
        resolve_valid_in  = 1'b1;
        resolve_pc_in     = p;
        resolve_taken_in  = tk;
        resolve_target_in = tg;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_valid_in = 1'b0; redirect_pc_in = '0;
        resolve_valid_in = 1'b0; resolve_pc_in = '0; resolve_target_in = '0;
        resolve_taken_in = 1'b0; imem_req_ready_in = 1'b0; imem_resp_valid_in = 1'b0;
        imem_resp_data_in = '0;
        repeat (3) step();
        reset = 1'b0; imem_req_ready_in = 1'b1;
        #1;
        chk("lit_first_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
        chk("lit_first_req_addr", imem_req_addr_out, 32'h0000_1000);

        // sequential fetch with 1-cycle memory
        wait_deliver("d1000");
        chk("lit_pc_1000", pc_out, 32'h0000_1000);
        chk("lit_instr_1000", instr_out, 32'hEFFF_1000);
        chk("lit_pc4_1000", pc_plus4_out, 32'h0000_1004);
        chk("lit_pred_1000", {31'd0, pred_taken_out}, 32'd0);
        step();
        chk("lit_req_1004", imem_req_addr_out, 32'h0000_1004);
        wait_deliver("d1004");
        chk("lit_pc_1004", pc_out, 32'h0000_1004);
        step();
        chk("lit_req_1008", imem_req_addr_out, 32'h0000_1008);
        wait_deliver("d1008");
        chk("lit_pc4_1008", pc_plus4_out, 32'h0000_100C);

        // stall on arrival holds the word, then releases by +4
        wait_deliver("d100c");
        stall_in = 1'b1;
        #1;
        chk("lit_stall_show", {31'd0, imem_stall_out}, 32'd0);
        repeat (3) begin
            step();
            chk("lit_hold_pc", pc_out, 32'h0000_100C);
            chk("lit_hold_instr", instr_out, 32'hEFF3_100C);
            chk("lit_hold_noreq", {31'd0, imem_req_valid_out}, 32'd0);
        end
        stall_in = 1'b0;
        step();
        chk("lit_req_1010", imem_req_addr_out, 32'h0000_1010);

        // BTB allocate on taken resolve, then train down
        resolve(32'h0000_1010, 1'b1, 32'h0000_2000);
        wait_deliver("d1010");
        chk("lit_pred_1010", {31'd0, pred_taken_out}, 32'd1);
        step();
        chk("lit_req_2000", imem_req_addr_out, 32'h0000_2000);
        wait_deliver("d2000");
        chk("lit_pred_2000", {31'd0, pred_taken_out}, 32'd0);
        step();

        // memory not ready for 5 cycles; not-taken training and a redirect meanwhile
        imem_req_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lit_nr_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
            chk("lit_nr_req_addr", imem_req_addr_out, 32'h0000_2004);
            chk("lit_nr_stall", {31'd0, imem_stall_out}, 32'd1);
            if (i == 1 || i == 2) resolve(32'h0000_1010, 1'b0, 32'h0000_0000);
            if (i == 4) begin
                redirect_valid_in = 1'b1;
                redirect_pc_in    = 32'h0000_1010;
            end
            step();
        end
        imem_req_ready_in = 1'b1;
        #1;
        chk("lit_req_1010b", imem_req_addr_out, 32'h0000_1010);
        wait_deliver("d1010b");
        chk("lit_pred_1010b", {31'd0, pred_taken_out}, 32'd0);
        step();
        chk("lit_req_1014", imem_req_addr_out, 32'h0000_1014);

        // redirect while waiting; stale response arrives two cycles later
        lat = 3;
        step();
        chk("lit_wait_stall", {31'd0, imem_stall_out}, 32'd1);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h0000_3000;
        step();
        chk("lit_drop_noreq", {31'd0, imem_req_valid_out}, 32'd0);
        step();
        chk("lit_stale_instr", instr_out, NOP);
        chk("lit_stale_stall", {31'd0, imem_stall_out}, 32'd1);
        lat = 1;
        step();
        chk("lit_req_3000", imem_req_addr_out, 32'h0000_3000);

        // redirect together with response and stall: no HOLD
        wait_deliver("d3000");
        chk("lit_instr_3000", instr_out, 32'hCFFF_3000);
        stall_in          = 1'b1;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h0000_4000;
        #1;
        chk("lit_redir_nop", instr_out, NOP);
        chk("lit_redir_stall", {31'd0, imem_stall_out}, 32'd1);
        step();
        chk("lit_redir_req", {31'd0, imem_req_valid_out}, 32'd1);
        chk("lit_req_4000", imem_req_addr_out, 32'h0000_4000);
        stall_in = 1'b0;

        // reset while holding an instruction
        wait_deliver("d4000");
        stall_in = 1'b1;
        step();
        chk("lit_hold_4000", pc_out, 32'h0000_4000);
        reset = 1'b1;
        imem_req_ready_in = 1'b0;
        step();
        reset = 1'b0; stall_in = 1'b0; imem_req_ready_in = 1'b1;
        #1;
        chk("lit_rst_req_addr", imem_req_addr_out, 32'h0000_1000);
        chk("lit_rst_stall", {31'd0, imem_stall_out}, 32'd1);

        // random soak against the model
        for (int i = 0; i < 300; i++) begin
            lat               = $urandom_range(1, 3);
            imem_req_ready_in = ($urandom_range(0, 3) != 0);
            stall_in          = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                resolve(32'h0000_1000 + 32'($urandom_range(0, 31)) * 4, 1'($urandom_range(0, 1)),
                        32'h0000_1000 + 32'($urandom_range(0, 31)) * 4);
            end
            if ($urandom_range(0, 11) == 0 && !(imem_req_valid_out && imem_req_ready_in)) begin
                redirect_valid_in = 1'b1;
                redirect_pc_in    = 32'h0000_1000 + 32'($urandom_range(0, 31)) * 4;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the in-order 5-stage pipeline. It owns the PC register and issues one instruction-memory request at a time over a valid/ready port. It presents the fetched instruction, PC, PC+4 and a prediction bit to the F->D pipeline register. A direct-mapped BTB with 2-bit counters supplies next-PC prediction and is trained by branch resolution from EX.

Parameters:
XLEN, 32, data/address width
ILEN, 32, instruction width
RESET_PC, 32'h0000_1000, PC value after reset
BTB_ENTRIES, 16, BTB entry count (power of 2); IDX = log2(BTB_ENTRIES)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stall_in  in  1  hazard unit holds F->D register; fetch must not advance
redirect_valid_in  in  1  mispredict/jump correction from EX
redirect_pc_in  in  XLEN  corrected PC
resolve_valid_in  in  1  resolved branch/jump in EX this cycle
resolve_pc_in  in  XLEN  PC of resolved instruction
resolve_target_in  in  XLEN  computed target
resolve_taken_in  in  1  actual direction
imem_req_valid_out  out  1  fetch request
imem_req_addr_out  out  XLEN  request address (= pc)
imem_req_ready_in  in  1  memory accepts request
imem_resp_valid_in  in  1  response data valid
imem_resp_data_in  in  ILEN  fetched word
instr_out  out  ILEN  instruction to decode (NOP 32'h0000_0013 when none)
pc_out  out  XLEN  PC of instr_out
pc_plus4_out  out  XLEN  pc_out + 4
pred_taken_out  out  1  BTB predicted taken for instr_out
imem_stall_out  out  1  no valid instruction this cycle (to hazard unit)

Behaviour:
- Reset: pc=RESET_PC, FSM=REQ, all BTB valid bits=0, hold buffer cleared. Outputs in the reset cycle and after: imem_req_valid_out=1, instr_out=NOP, pred_taken_out=0, imem_stall_out=1.
- FSM states:
  - REQ: imem_req_valid_out=1, addr=pc. req_valid & ready moves to WAIT.
  - WAIT: waits for a response. One outstanding request max; response arrives ≥1 cycle after acceptance.
  - HOLD: instruction buffered while stall_in=1.
  - DROP: discards the stale response after a redirect.
- Fetch valid: resp_valid in WAIT, or in HOLD. When valid, instr_out=data (live or buffered), pc_out=pc, pc_plus4_out=pc+4, pred_taken_out=prediction, imem_stall_out=0. Otherwise instr_out=NOP, pred_taken_out=0, imem_stall_out=1.
- Advance when fetch valid & !stall_in: pc <= next_pc, FSM goes to REQ. Fetch valid & stall_in: latch data and prediction, go to HOLD, remain until !stall_in. Best-case throughput is 1 instruction per 2 cycles (REQ, WAIT).
- Prediction, combinational on pc:
  - index = pc[IDX+1:2]; hit = valid & tag==pc[XLEN-1:IDX+2].
  - pred_taken = hit & ctr[1]; next_pc = pred_taken ? target : pc+4 (32-bit wrap).
- BTB update on resolve_valid_in, indexed by resolve_pc_in:
  - taken & miss: allocate tag and target, ctr=2'b10.
  - taken & hit: write target, ctr saturating increment to 2'b11.
  - not-taken & hit: ctr saturating decrement to 2'b00.
  - not-taken & miss: no change.
  - Write is visible next cycle; a same-cycle lookup at the same index sees the old contents.
- Redirect has highest priority, over stall_in and advance:
  - pc <= redirect_pc_in; fetch-valid outputs forced to NOP/0 that cycle.
  - From REQ or HOLD: go to REQ; buffer discarded.
  - From WAIT without resp_valid this cycle: go to DROP. From WAIT with resp_valid this cycle: response discarded, go to REQ.
  - DROP goes to REQ when resp_valid arrives; that data is never output.
  - A second redirect while in DROP updates pc and stays in DROP.
- imem_resp_valid_in while in REQ is ignored, covering responses in flight across reset.
- Reset mid-operation restores the reset state next cycle regardless of FSM state.

Test Plan:
- Reset then memory with 1-cycle response, ready=1: requests at 0x1000, 0x1004, 0x1008; instr_out shows each word for one cycle with pc_plus4_out=pc+4 and pred_taken_out=0.
- stall_in=1 for 3 cycles when a response arrives: instr_out holds the same word and pc_out stays; no new request; release advances pc by 4.
- Resolve pc=0x1010 taken, target=0x2000: next fetch of 0x1010 gives pred_taken_out=1 and the following request goes to 0x2000. Two not-taken resolves then predict not-taken (0x1014).
- Redirect to 0x3000 in WAIT, response 2 cycles later: stale word never appears on instr_out; next request is 0x3000.
- Redirect coincident with resp_valid and stall_in=1: response dropped, FSM returns to REQ, no HOLD entered.
- ready=0 for 5 cycles: req_valid and addr held stable, imem_stall_out=1 throughout.
